// File: rtl/wish_pkg.sv
// Shared Wishbone FSM constants for the master and slave state machines.
// Default bus widths and the 2-bit state encoding live here.
package wish_pkg;

    localparam int WISH_AW = 32;
    localparam int WISH_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } wish_state_t;

endpackage

// File: rtl/wish_master_fsm_if.sv
// Processor request side plus Wishbone classic initiator side of wish_master_fsm.
// master modport is the FSM's view; slave modport is the processor/bus environment.
interface wish_master_fsm_if
    import wish_pkg::*;
#(
    parameter int AW = WISH_AW,
    parameter int DW = WISH_DW
) ();

    localparam int SW = DW / 8;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [SW-1:0] cpu_sel;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          cpu_err;

    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_ack_i;
    logic [DW-1:0] wb_dat_i;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel, wb_ack_i, wb_dat_i,
        output cpu_ready, cpu_rdata, cpu_done, cpu_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel, wb_ack_i, wb_dat_i,
        input  cpu_ready, cpu_rdata, cpu_done, cpu_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

endinterface

// File: rtl/wish_master_fsm.sv
// Wishbone classic single-transfer initiator: one cpu request -> one bus cycle -> done/err pulse.
// Latency: req edge to cpu_done = 2 cycles + slave wait states; one idle cycle after each transfer.
// Backpressure: cpu_ready low outside IDLE; WISH_MASTER_TIMEOUT_EN adds an ack timeout -> cpu_err.
module wish_master_fsm
    import wish_pkg::*;
#(
    parameter int AW      = WISH_AW,
    parameter int DW      = WISH_DW,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    wish_master_fsm_if.master  bus
);

    localparam int SW = DW / 8;

    // Parameter sanity: this branch is only elaborated for an illegal configuration.
    if (TIMEOUT < 2 || TIMEOUT > 255 || (DW % 8) != 0) begin : g_bad_params
    end

    wish_state_t   state;
    wish_state_t   state_nxt;

    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] rdata_q;

`ifdef WISH_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.cpu_req) state_nxt = ST_BUS;
            ST_BUS: begin
                if (bus.wb_ack_i) begin
                    state_nxt = ST_DONE;
                end
`ifdef WISH_MASTER_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    state_nxt = ST_ERR;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state == ST_IDLE && bus.cpu_req) begin
                we_q  <= bus.cpu_we;
                adr_q <= bus.cpu_addr;
                dat_q <= bus.cpu_wdata;
                sel_q <= bus.cpu_sel;
            end
            if (state == ST_BUS && bus.wb_ack_i && !we_q) begin
                rdata_q <= bus.wb_dat_i;
            end
        end
    end

`ifdef WISH_MASTER_TIMEOUT_EN
    // Held at zero outside BUS so every transfer starts counting from 0.
    always_ff @(posedge clk) begin
        if (reset || state != ST_BUS) begin
            wait_cnt <= '0;
        end else if (!bus.wb_ack_i) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
    assign bus.cpu_err = (state == ST_ERR);
`else
    assign bus.cpu_err = 1'b0;
`endif

    assign bus.cpu_ready = (state == ST_IDLE);
    assign bus.cpu_done  = (state == ST_DONE);
    assign bus.cpu_rdata = rdata_q;
    assign bus.wb_cyc_o  = (state == ST_BUS);
    assign bus.wb_stb_o  = (state == ST_BUS);
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_sel_o  = (state == ST_BUS) ? sel_q : '0;

endmodule

// File: tb/tb_wish_master_fsm.sv
// Directed plus randomized bench for wish_master_fsm with a transaction-level reference model.
module tb_wish_master_fsm;
    import wish_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic reset;

    wish_master_fsm_if #(.AW(AW), .DW(DW)) bus ();

    wish_master_fsm #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer as the processor and a slave with `waits` wait states see it.
    task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] sel, input int waits, input logic [DW-1:0] rd,
                        input bit hold_req);
        chk("req_ready", 64'(bus.cpu_ready), 64'd1);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_sel   = sel;
        bus.wb_ack_i  = 1'b0;
        @(negedge clk);
        if (!hold_req) bus.cpu_req = 1'b0;
        // Scramble the request inputs: the bus must keep the latched copy.
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
        bus.cpu_sel   = SW'($urandom);
        for (int k = 0; k <= waits; k++) begin
            chk("bus_cyc",   64'(bus.wb_cyc_o),  64'd1);
            chk("bus_stb",   64'(bus.wb_stb_o),  64'd1);
            chk("bus_we",    64'(bus.wb_we_o),   64'(we));
            chk("bus_adr",   64'(bus.wb_adr_o),  64'(a));
            chk("bus_dat",   64'(bus.wb_dat_o),  64'(wd));
            chk("bus_sel",   64'(bus.wb_sel_o),  64'(sel));
            chk("bus_ready", 64'(bus.cpu_ready), 64'd0);
            chk("bus_done",  64'(bus.cpu_done),  64'd0);
            bus.wb_ack_i = (k == waits);
            bus.wb_dat_i = (k == waits) ? rd : $urandom;
            @(negedge clk);
        end
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = $urandom;
        if (!we) exp_rdata = rd;
        chk("done_pulse", 64'(bus.cpu_done),  64'd1);
        chk("done_cyc",   64'(bus.wb_cyc_o),  64'd0);
        chk("done_ready", 64'(bus.cpu_ready), 64'd0);
        chk("done_err",   64'(bus.cpu_err),   64'd0);
        chk("done_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
        @(negedge clk);
        chk("idle_done",  64'(bus.cpu_done),  64'd0);
        chk("idle_ready", 64'(bus.cpu_ready), 64'd1);
        chk("idle_cyc",   64'(bus.wb_cyc_o),  64'd0);
        chk("idle_sel",   64'(bus.wb_sel_o),  64'd0);
        chk("idle_adr",   64'(bus.wb_adr_o),  64'(a));
        chk("idle_we",    64'(bus.wb_we_o),   64'(we));
        chk("idle_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
    endtask

    initial begin
        reset         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_sel   = '0;
        bus.wb_ack_i  = 1'b0;
        bus.wb_dat_i  = '0;
        exp_rdata     = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.cpu_ready), 64'd1);
        chk("rst_done",  64'(bus.cpu_done),  64'd0);
        chk("rst_err",   64'(bus.cpu_err),   64'd0);
        chk("rst_cyc",   64'(bus.wb_cyc_o),  64'd0);
        chk("rst_stb",   64'(bus.wb_stb_o),  64'd0);
        chk("rst_we",    64'(bus.wb_we_o),   64'd0);
        chk("rst_adr",   64'(bus.wb_adr_o),  64'd0);
        chk("rst_dat",   64'(bus.wb_dat_o),  64'd0);
        chk("rst_sel",   64'(bus.wb_sel_o),  64'd0);
        chk("rst_rdata", 64'(bus.cpu_rdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait read, then a write with 3 wait states (rdata must not move).
        xfer(1'b0, 32'h10, 32'hA5A5_0000, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b1, 32'h20, 32'h1234_5678, 4'hF, 3, 32'h0BAD_F00D, 1'b0);

        // Back-to-back with cpu_req held high through the first transfer.
        xfer(1'b0, 32'h30, 32'h0, 4'h3, 1, 32'hCAFE_0001, 1'b1);
        xfer(1'b1, 32'h34, 32'h5555_AAAA, 4'hC, 0, 32'h0, 1'b0);

        // Reset while a read sits in its second wait cycle.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h40;
        bus.cpu_sel  = 4'hF;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        chk("rstmid_cyc0", 64'(bus.wb_cyc_o), 64'd1);
        @(negedge clk);
        chk("rstmid_cyc1", 64'(bus.wb_cyc_o), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = '0;
        chk("rstmid_cyc",   64'(bus.wb_cyc_o),  64'd0);
        chk("rstmid_stb",   64'(bus.wb_stb_o),  64'd0);
        chk("rstmid_ready", 64'(bus.cpu_ready), 64'd1);
        chk("rstmid_done",  64'(bus.cpu_done),  64'd0);
        chk("rstmid_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h7777_7777;
        repeat (2) begin
            @(negedge clk);
            chk("lateack_done",  64'(bus.cpu_done),  64'd0);
            chk("lateack_ready", 64'(bus.cpu_ready), 64'd1);
        end
        bus.wb_ack_i = 1'b0;

        // Spurious ack in IDLE for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = $urandom;
            @(negedge clk);
            chk("spur_ready", 64'(bus.cpu_ready), 64'd1);
            chk("spur_done",  64'(bus.cpu_done),  64'd0);
            chk("spur_cyc",   64'(bus.wb_cyc_o),  64'd0);
            chk("spur_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
        end
        bus.wb_ack_i = 1'b0;

`ifdef WISH_MASTER_TIMEOUT_EN
        // TIMEOUT=4: four unacked BUS cycles, then one cycle of cpu_err.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h50;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("to_cyc", 64'(bus.wb_cyc_o), 64'd1);
            chk("to_err", 64'(bus.cpu_err),  64'd0);
            @(negedge clk);
        end
        chk("to_err_pulse", 64'(bus.cpu_err),   64'd1);
        chk("to_err_done",  64'(bus.cpu_done),  64'd0);
        chk("to_err_cyc",   64'(bus.wb_cyc_o),  64'd0);
        chk("to_err_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
        @(negedge clk);
        chk("to_after_err",   64'(bus.cpu_err),   64'd0);
        chk("to_after_ready", 64'(bus.cpu_ready), 64'd1);
        // Ack exactly at the limit wins over the timeout.
        xfer(1'b0, 32'h54, 32'h0, 4'hF, 3, 32'h1357_9BDF, 1'b0);
`endif

        // Randomized transfers with random idle gaps and stray acks.
        for (int n = 0; n < 40; n++) begin
            int gap;
            int waits;
            gap = $urandom_range(0, 2);
`ifdef WISH_MASTER_TIMEOUT_EN
            waits = $urandom_range(0, 3);
`else
            waits = $urandom_range(0, 5);
`endif
            for (int g = 0; g < gap; g++) begin
                bus.wb_ack_i = 1'($urandom);
                @(negedge clk);
                chk("gap_ready", 64'(bus.cpu_ready), 64'd1);
                chk("gap_done",  64'(bus.cpu_done),  64'd0);
            end
            bus.wb_ack_i = 1'b0;
            xfer(1'($urandom), $urandom, $urandom, SW'($urandom), waits, $urandom, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wish_master_fsm.md
Name: wish_master_fsm

Overview:
- Wishbone classic single-transfer initiator.
- Converts one processor memory request (load/store from the multicycle RISC-V datapath) into a Wishbone cycle.
- Drives the bus towards the memory-controller slave, waits for ack, returns read data and a done pulse to the processor.
- Sits between the processor memory interface and the Wishbone slave FSM of the memory controller.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- SW, DW/8, byte-select width (derived, not overridden).
- TIMEOUT, 16, ack wait limit in cycles; used only with the optional feature; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only when cpu_ready=1.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  write data.
- cpu_sel  in  SW  byte enables.
- cpu_ready  out  1  high in IDLE; request may be presented.
- cpu_rdata  out  DW  read data, valid from cpu_done onward; held until the next read completes.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  one-cycle error pulse (tied 0 without the optional feature).
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  AW  address.
- wb_dat_o  out  DW  write data.
- wb_sel_o  out  SW  byte select.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  DW  slave read data.

Behaviour:
- Reset values: all outputs 0 except cpu_ready=1. State=IDLE. Request registers and cpu_rdata cleared.
- Reset mid-transfer: cyc/stb go low on the same edge. No done or err pulse is issued. Any late ack is ignored.
- State IDLE (cpu_ready=1):
  - On cpu_req=1, latch we/addr/wdata/sel into registers and go to BUS.
  - wb_ack_i is ignored in IDLE.
- State BUS (cyc=stb=1):
  - wb_we/adr/dat/sel driven from the latched registers and stable for the whole state.
  - cpu_ready=0; cpu_req is ignored.
  - On wb_ack_i=1 sampled at a rising edge: if read, capture wb_dat_i into cpu_rdata; go to DONE.
  - Without ack, stay in BUS indefinitely (no optional feature).
- State DONE:
  - cyc=stb=0. cpu_done=1 for exactly this cycle.
  - Next state is IDLE unconditionally, giving one bus-idle turnaround cycle between transfers.
  - A slave that acks on the same edge stb rises yields minimum latency: cpu_req edge to cpu_done high = 2 cycles. Each extra wait state adds 1 cycle.
- All outputs are registered or decoded from state only. There is no combinational path from wb_ack_i to cpu_done.
- wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o hold their last value outside BUS. wb_sel_o is forced 0 when cyc=0.

Optional Feature:
- Macro: WISH_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to BUS and increments each BUS cycle without ack.
  - If the counter reaches TIMEOUT-1 with no ack, go to state ERR: cyc=stb=0, cpu_err=1 for one cycle, cpu_rdata unchanged, then IDLE.
  - Ack in the same cycle as the limit wins: normal DONE, no error.
- Undefined: no counter, no ERR state, cpu_err tied 0.

Decomposition:
- Shared package wish_pkg:
  - 2-bit state encodings IDLE=0, BUS=1, DONE=2, ERR=3.
  - Default AW/DW constants.
  - The same package serves the slave FSM constants.
- Single module. No sub-module; the timeout counter stays inline.

Test Plan:
- Zero-wait read: cpu_req with addr=0x10 while the slave acks in the first stb cycle with dat_i=0xDEADBEEF → cyc/stb high 1 cycle, cpu_done 2 cycles after req, cpu_rdata=0xDEADBEEF.
- Write with 3 wait states: addr=0x20, wdata=0x12345678, sel=0xF → adr/dat/sel/we=1 stable for 4 cycles, cpu_done on the 5th cycle, cpu_rdata unchanged.
- Back-to-back: a second cpu_req held high through the first transfer → ignored while busy. Second cycle starts only after DONE→IDLE, with exactly 1 cycle of cyc=0 between the transfers.
- Reset at the 2nd wait cycle of a read → cyc/stb=0 and cpu_ready=1 after that edge, no cpu_done. A later ack=1 produces no pulse.
- Spurious ack in IDLE (ack=1 for 3 cycles, no req) → no state change, no done.
- With WISH_MASTER_TIMEOUT_EN and TIMEOUT=4, no ack → cpu_err pulses 1 cycle after 4 BUS cycles. Ack on the 4th cycle instead → cpu_done, cpu_err=0.
